// File: rtl/shift_reg_pkg.sv
// Shared types and the single-step datapath function for shift_reg_universal.
// step() works on a zero-extended MaxWidth vector so any WIDTH up to MaxWidth can reuse it.
package shift_reg_pkg;

  localparam int unsigned MaxWidth = 64;

  typedef enum logic [2:0] {
    MODE_HOLD,
    MODE_LOAD,
    MODE_SHL,
    MODE_SHR,
    MODE_ROL,
    MODE_ROR,
    MODE_CLR,
    MODE_INV
  } mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  function automatic logic is_shift(mode_t m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

  // Returns {sout_next, q_next}. LOAD is resolved by the caller since it needs d.
  // q must arrive with bits at and above width cleared.
  function automatic logic [MaxWidth:0] step(logic [MaxWidth-1:0] q, int unsigned width,
                                             mode_t mode, logic sin, logic sout);
    logic [MaxWidth-1:0] q_n;
    logic [MaxWidth-1:0] mask;
    logic [MaxWidth-1:0] top;
    logic                msb;
    logic                so;
    mask = '0;
    for (int unsigned i = 0; i < MaxWidth; i++) mask[i] = (i < width);
    top = q >> (width - 1);
    msb = top[0];
    so  = sout;
    q_n = q;
    case (mode)
      MODE_SHL: begin
        q_n = (q << 1) | MaxWidth'(sin);
        so  = msb;
      end
      MODE_SHR: begin
        q_n = (q >> 1) | (MaxWidth'(sin) << (width - 1));
        so  = q[0];
      end
      MODE_ROL: begin
        q_n = (q << 1) | MaxWidth'(msb);
        so  = msb;
      end
      MODE_ROR: begin
        q_n = (q >> 1) | (MaxWidth'(q[0]) << (width - 1));
        so  = q[0];
      end
      MODE_CLR: q_n = '0;
      MODE_INV: q_n = ~q;
      default:  q_n = q;
    endcase
    return {so, q_n & mask};
  endfunction

endpackage

// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal register: per-cycle modes plus a counted burst-shift engine
// with start/busy/done handshake.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  localparam int unsigned      CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  mode_t            mode_lat_q, mode_lat_d;
  logic             sin_lat_q, sin_lat_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  mode_t             step_mode;
  logic              step_sin;
  logic [MaxWidth:0] res;
  logic [CNT_W-1:0]  cnt_sat;

  assign cnt_sat = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    sout_d     = sout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mode_lat_d = mode_lat_q;
    sin_lat_d  = sin_lat_q;
    rem_d      = rem_q;

    // In a burst the latched operation replaces the live inputs.
    step_mode = mode_t'(mode);
    step_sin  = sin;
    if (state_q == ST_BURST) begin
      step_mode = mode_lat_q;
      step_sin  = sin_lat_q;
    end
    res = step(MaxWidth'(q_q), WIDTH, step_mode, step_sin, sout_q);

    unique case (state_q)
      ST_IDLE: begin
        if (start && is_shift(step_mode)) begin
          if (cnt_sat == '0) begin
            done_d = 1'b1;
          end else begin
            q_d        = res[WIDTH-1:0];
            sout_d     = res[MaxWidth];
            mode_lat_d = step_mode;
            sin_lat_d  = sin;
            rem_d      = cnt_sat - CNT_W'(1);
            if (cnt_sat == CNT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_BURST;
              busy_d  = 1'b1;
            end
          end
        end else if (step_mode == MODE_LOAD) begin
          q_d = d;
        end else begin
          q_d    = res[WIDTH-1:0];
          sout_d = res[MaxWidth];
        end
      end
      ST_BURST: begin
        q_d    = res[WIDTH-1:0];
        sout_d = res[MaxWidth];
        rem_d  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      q_q        <= RESET_VALUE;
      sout_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mode_lat_q <= MODE_HOLD;
      sin_lat_q  <= 1'b0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      sout_q     <= sout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mode_lat_q <= mode_lat_d;
      sin_lat_q  <= sin_lat_d;
      rem_q      <= rem_d;
    end
  end

  if (WIDTH < MaxWidth) begin : g_unused
    logic unused_res_hi;
    assign unused_res_hi = ^res[MaxWidth-1:WIDTH];
  end

  assign q    = q_q;
  assign nq   = ~q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed plus randomized bench for shift_reg_universal against an arithmetic reference model.
module tb_shift_reg_universal;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  RV = 8'hA5;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          nreset;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          sin;
  logic          start;
  logic [CW-1:0] count;
  logic [W-1:0]  q;
  logic [W-1:0]  nq;
  logic          sout;
  logic          busy;
  logic          done;

  shift_reg_universal #(
    .WIDTH      (W),
    .RESET_VALUE(RV)
  ) u_dut (
    .clock (clock),
    .nreset(nreset),
    .mode  (mode),
    .d     (d),
    .sin   (sin),
    .start (start),
    .count (count),
    .q     (q),
    .nq    (nq),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register value as an integer 0..255, burst as steps left.
  int m_q, m_sout, m_busy, m_done, m_left, m_mode, m_sin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = int'(RV); m_sout = 0; m_busy = 0; m_done = 0; m_left = 0;
  endtask

  task automatic model_apply(input int md, input int s, input int din);
    int old;
    old = m_q;
    case (md)
      1: m_q = din;
      2: begin m_sout = old / 128; m_q = (old * 2) % 256 + s; end
      3: begin m_sout = old % 2; m_q = old / 2 + s * 128; end
      4: begin m_sout = old / 128; m_q = (old * 2) % 256 + old / 128; end
      5: begin m_sout = old % 2; m_q = old / 2 + (old % 2) * 128; end
      6: m_q = 0;
      7: m_q = 255 - old;
      default: ;
    endcase
  endtask

  task automatic model_edge();
    int n;
    m_done = 0;
    if (m_busy == 0) begin
      if (start && mode >= 2 && mode <= 5) begin
        n = (int'(count) > int'(W)) ? int'(W) : int'(count);
        if (n == 0) m_done = 1;
        else begin
          model_apply(int'(mode), int'(sin), int'(d));
          m_mode = int'(mode); m_sin = int'(sin); m_left = n - 1;
          if (m_left == 0) m_done = 1;
          else m_busy = 1;
        end
      end else model_apply(int'(mode), int'(sin), int'(d));
    end else begin
      model_apply(m_mode, m_sin, 0);
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_done = 1; end
    end
  endtask

  task automatic check_all();
    check("q", 32'(q), 32'(m_q));
    check("nq", 32'(nq), 32'(255 - m_q));
    check("sout", 32'(sout), 32'(m_sout));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic drive(input int md, input int dv, input int s, input int st, input int c);
    mode = 3'(md); d = 8'(dv); sin = 1'(s); start = 1'(st); count = CW'(c);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic reset_pulse();
    @(posedge clock);
    model_edge();
    #2 nreset = 1'b0;
    model_reset();
    #1 check_all();
    #1 nreset = 1'b1;
    @(negedge clock);
    check_all();
  endtask

  int steps;
  int done_at[$];

  initial begin
    nreset = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    check_all();
    nreset = 1'b1;

    // Mid-cycle async reset after disturbing q.
    drive(1, 8'h3C, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    reset_pulse();
    check("rst_q", 32'(q), 32'h0A5);
    check("rst_nq", 32'(nq), 32'h05A);

    // Single-step sequence.
    drive(1, 8'h81, 0, 0, 0); cycle();
    drive(4, 0, 0, 0, 0); cycle();
    check("rol_q", 32'(q), 32'h03); check("rol_sout", 32'(sout), 32'h1);
    drive(3, 0, 0, 0, 0); cycle();
    check("shr_q", 32'(q), 32'h01); check("shr_sout", 32'(sout), 32'h1);
    drive(7, 0, 0, 0, 0); cycle();
    check("inv_q", 32'(q), 32'hFE);
    drive(6, 0, 0, 0, 0); cycle();
    check("clr_q", 32'(q), 32'h00);

    // Burst SHL x3 from 8'h01, with noise on inputs and a start while busy.
    drive(1, 8'h01, 0, 0, 0); cycle();
    drive(2, 0, 0, 1, 3); cycle();
    check("b_busy1", 32'(busy), 32'h1);
    drive(1, 8'hFF, 1, 1, 5); cycle();
    check("b_busy2", 32'(busy), 32'h1);
    drive(7, 8'h55, 1, 0, 0); cycle();
    check("b_done", 32'(done), 32'h1);
    check("b_q", 32'(q), 32'h08);
    check("b_idle", 32'(busy), 32'h0);
    drive(0, 0, 0, 0, 0); cycle();
    check("b_done_once", 32'(done), 32'h0);

    // count=0: no change, one done pulse, never busy.
    drive(1, 8'h5A, 0, 0, 0); cycle();
    drive(2, 0, 1, 1, 0); cycle();
    check("c0_done", 32'(done), 32'h1);
    check("c0_busy", 32'(busy), 32'h0);
    check("c0_q", 32'(q), 32'h5A);
    drive(0, 0, 0, 0, 0); cycle();

    // Saturating count: ROR x15 behaves as x8.
    drive(1, 8'h3C, 0, 0, 0); cycle();
    drive(5, 0, 0, 1, 15); cycle();
    drive(0, 0, 0, 0, 0);
    steps = 1;
    while (!done && steps < 20) begin cycle(); steps++; end
    check("sat_steps", 32'(steps), 32'd8);
    check("sat_q", 32'(q), 32'h3C);
    cycle();

    // Reset mid-burst aborts with no done; a new start is then accepted.
    drive(1, 8'h3C, 0, 0, 0); cycle();
    drive(4, 0, 0, 1, 8); cycle();
    drive(0, 0, 0, 0, 0); cycle(); cycle();
    reset_pulse();
    check("ab_q", 32'(q), 32'h0A5);
    check("ab_busy", 32'(busy), 32'h0);
    cycle(); cycle();
    check("ab_nodone", 32'(done), 32'h0);
    drive(2, 0, 1, 1, 1); cycle();
    check("ab_new_done", 32'(done), 32'h1);
    check("ab_new_q", 32'(q), 32'h4B);

    // Back-to-back bursts with start held.
    drive(6, 0, 0, 0, 0); cycle();
    drive(2, 0, 1, 1, 2);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      if (done) done_at.push_back(i);
    end
    check("bb_ndone", 32'(done_at.size()), 32'd2);
    if (done_at.size() == 2) begin
      check("bb_done1", 32'(done_at[0]), 32'd2);
      check("bb_done2", 32'(done_at[1]), 32'd4);
    end
    check("bb_q", 32'(q), 32'h0F);
    drive(0, 0, 0, 0, 0); cycle(); cycle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0,
            int'($urandom_range(0, 15)));
      if ($urandom_range(0, 49) == 0) reset_pulse();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
